// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: feeds the FIR MAC one (sample, coefficient) pair per clock.
// It holds the sample delay line and the coefficient bank. For each accepted sample
// it streams TAPS operand pairs, flags tap 0, then pulses done for one cycle.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid/in_data         sample offer; accepted only while in_ready is high
//   in_ready                 high only while idle
//   coef_we/addr/data        coefficient write port; honoured only while idle
//   mac_x/mac_b              sample and coefficient operands; zero when mac_valid is low
//   mac_valid/mac_first      live-tap flag and tap-0 flag
//   tap_idx                  index of the tap currently presented
//   done                     one-cycle pulse after the last tap
module fir_tap_sequencer #(
    parameter int unsigned TAPS = 8,
    parameter int unsigned DW   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DW-1:0]           in_data,
    output logic                    in_ready,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [DW-1:0]           coef_data,
    output logic [DW-1:0]           mac_x,
    output logic [DW-1:0]           mac_b,
    output logic                    mac_valid,
    output logic                    mac_first,
    output logic [$clog2(TAPS)-1:0] tap_idx,
    output logic                    done
);

    localparam int unsigned AW = $clog2(TAPS);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q;
    logic [DW-1:0] delay_q [TAPS];
    logic [DW-1:0] coef_q  [TAPS];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] newest_q;

    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] k_d;
    logic [PW-1:0] diff_d;
    logic [AW-1:0] rd_idx_d;
    logic          coef_wr_ok;
    logic [DW-1:0] coef0_d;
    logic          last_tap;

    // Pointer arithmetic, kept modulo TAPS so that non-power-of-2 tap counts work.
    always_comb begin
        wr_ptr_d   = (wr_ptr_q == AW'(TAPS - 1)) ? '0 : wr_ptr_q + AW'(1);
        k_d        = tap_idx + AW'(1);
        // newest - k mod TAPS, computed as newest + TAPS - k to stay non-negative
        diff_d     = {1'b0, newest_q} + PW'(TAPS) - {1'b0, k_d};
        rd_idx_d   = (diff_d >= PW'(TAPS)) ? AW'(diff_d - PW'(TAPS)) : AW'(diff_d);
        coef_wr_ok = coef_we && ({1'b0, coef_addr} < PW'(TAPS));
        // Tap 0 is issued on the accept edge, so a same-edge write to coef[0] is forwarded.
        coef0_d    = (coef_wr_ok && (coef_addr == '0)) ? coef_data : coef_q[0];
        last_tap   = (tap_idx == AW'(TAPS - 1));
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            newest_q  <= '0;
            in_ready  <= 1'b1;
            mac_x     <= '0;
            mac_b     <= '0;
            mac_valid <= 1'b0;
            mac_first <= 1'b0;
            tap_idx   <= '0;
            done      <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (coef_wr_ok) begin
                        coef_q[coef_addr] <= coef_data;
                    end
                    if (in_valid) begin
                        // Tap 0 is the sample being stored this edge.
                        delay_q[wr_ptr_q] <= in_data;
                        newest_q          <= wr_ptr_q;
                        wr_ptr_q          <= wr_ptr_d;
                        state_q           <= RUN;
                        in_ready          <= 1'b0;
                        mac_x             <= in_data;
                        mac_b             <= coef0_d;
                        mac_valid         <= 1'b1;
                        mac_first         <= 1'b1;
                        tap_idx           <= '0;
                    end
                end
                RUN: begin
                    mac_first <= 1'b0;
                    if (last_tap) begin
                        state_q   <= DONE;
                        mac_x     <= '0;
                        mac_b     <= '0;
                        mac_valid <= 1'b0;
                        tap_idx   <= '0;
                        done      <= 1'b1;
                    end else begin
                        mac_x   <= delay_q[rd_idx_d];
                        mac_b   <= coef_q[k_d];
                        tap_idx <= k_d;
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    done     <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer: the stimulus side keeps a sample history
// and coefficient table, and pushes cycle-stamped expectations into queues. The monitor
// compares each cycle's outputs against those expectations.
module tb_fir_tap_sequencer;

    localparam int unsigned TAPS = 8;
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = $clog2(TAPS);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [DW-1:0] coef_data;
    logic [DW-1:0] mac_x;
    logic [DW-1:0] mac_b;
    logic          mac_valid;
    logic          mac_first;
    logic [AW-1:0] tap_idx;
    logic          done;

    fir_tap_sequencer #(.TAPS(TAPS), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .mac_x     (mac_x),
        .mac_b     (mac_b),
        .mac_valid (mac_valid),
        .mac_first (mac_first),
        .tap_idx   (tap_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned   cyc;
        logic [DW-1:0] x;
        logic [DW-1:0] b;
        logic          first;
        logic [AW-1:0] idx;
    } tap_t;

    tap_t          tq[$];
    int unsigned   dq[$];
    int unsigned   rq[$];
    logic [DW-1:0] hist[$];
    logic [DW-1:0] coef_m [TAPS];
    int unsigned   free_cyc = 0;
    bit            mon_en = 1'b0;
    int            checks = 0;
    int            failures = 0;
    tap_t          me;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference behaviour for one accepted sample driven at stimulus cycle n.
    task automatic model_accept(input logic [DW-1:0] d, input int unsigned n);
        tap_t e;
        hist.push_front(d);
        if (hist.size() > int'(TAPS)) void'(hist.pop_back());
        for (int k = 0; k < int'(TAPS); k++) begin
            e.cyc   = n + 1 + k;
            e.x     = (k < hist.size()) ? hist[k] : '0;
            e.b     = coef_m[k];
            e.first = (k == 0);
            e.idx   = AW'(k);
            tq.push_back(e);
        end
        for (int unsigned c = n + 1; c <= n + 1 + TAPS; c++) rq.push_back(c);
        dq.push_back(n + 1 + TAPS);
        free_cyc = n + TAPS + 2;
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] id, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] cd);
        in_valid  = iv;
        in_data   = id;
        coef_we   = we;
        coef_addr = a;
        coef_data = cd;
        if (cyc >= free_cyc) begin
            if (we && int'(a) < int'(TAPS)) coef_m[a] = cd;
            if (iv) model_accept(id, cyc);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic wait_free();
        while (cyc < free_cyc) drive(1'b0, '0, 1'b0, '0, '0);
    endtask

    // Reset lands on the next edge; expectations for later cycles are void.
    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        while (tq.size() > 0 && tq[tq.size()-1].cyc > cyc) void'(tq.pop_back());
        while (dq.size() > 0 && dq[dq.size()-1] > cyc) void'(dq.pop_back());
        while (rq.size() > 0 && rq[rq.size()-1] > cyc) void'(rq.pop_back());
        hist.delete();
        for (int k = 0; k < int'(TAPS); k++) coef_m[k] = '0;
        free_cyc = cyc + 1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (tq.size() > 0 && tq[0].cyc == cyc) begin
                me = tq.pop_front();
                chk("tap_valid", 32'(mac_valid), 32'(1));
                chk("tap_x",     32'(mac_x),     32'(me.x));
                chk("tap_b",     32'(mac_b),     32'(me.b));
                chk("tap_first", 32'(mac_first), 32'(me.first));
                chk("tap_idx",   32'(tap_idx),   32'(me.idx));
            end else begin
                chk("idle_valid", 32'(mac_valid), 32'(0));
                chk("idle_x",     32'(mac_x),     32'(0));
                chk("idle_b",     32'(mac_b),     32'(0));
                chk("idle_first", 32'(mac_first), 32'(0));
            end
            if (dq.size() > 0 && dq[0] == cyc) begin
                void'(dq.pop_front());
                chk("done_pulse", 32'(done), 32'(1));
            end else begin
                chk("done_quiet", 32'(done), 32'(0));
            end
            if (rq.size() > 0 && rq[0] == cyc) begin
                void'(rq.pop_front());
                chk("in_ready_busy", 32'(in_ready), 32'(0));
            end else begin
                chk("in_ready_idle", 32'(in_ready), 32'(1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        for (int k = 0; k < int'(TAPS); k++) coef_m[k] = '0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst      = 1'b0;
        free_cyc = cyc;
        mon_en   = 1'b1;

        // Reset state after idling
        repeat (3) drive(1'b0, '0, 1'b0, '0, '0);
        chk("rst_in_ready",  32'(in_ready),  32'(1));
        chk("rst_mac_valid", 32'(mac_valid), 32'(0));
        chk("rst_mac_x",     32'(mac_x),     32'(0));
        chk("rst_mac_b",     32'(mac_b),     32'(0));
        chk("rst_done",      32'(done),      32'(0));
        chk("rst_tap_idx",   32'(tap_idx),   32'(0));

        // Impulse against coef[k] = k+1
        for (int k = 0; k < int'(TAPS); k++) drive(1'b0, '0, 1'b1, AW'(k), DW'(k + 1));
        drive(1'b1, 16'h0001, 1'b0, '0, '0);
        wait_free();

        // Nine samples wrap the delay line
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, DW'(10 * i), 1'b0, '0, '0);
            wait_free();
        end

        // in_valid held through RUN: only the idle offers are taken
        drive(1'b1, 16'h0005, 1'b0, '0, '0);
        while (cyc < free_cyc) drive(1'b1, 16'h7FFF, 1'b0, '0, '0);
        drive(1'b1, 16'h7FFF, 1'b0, '0, '0);
        wait_free();

        // Coefficient write during RUN is dropped; in IDLE with an accept it applies
        drive(1'b1, 16'h0100, 1'b0, '0, '0);
        repeat (3) drive(1'b0, '0, 1'b1, AW'(3), 16'h00AA);
        wait_free();
        drive(1'b1, 16'h0002, 1'b0, '0, '0);
        wait_free();
        drive(1'b1, 16'h0003, 1'b1, AW'(3), 16'h00AA);
        wait_free();
        drive(1'b1, 16'h0004, 1'b1, AW'(0), 16'h0BEE);
        wait_free();

        // Reset while tap 4 is presented, then an impulse sees cleared coefficients
        drive(1'b1, 16'h0009, 1'b0, '0, '0);
        repeat (4) drive(1'b0, '0, 1'b0, '0, '0);
        do_reset();
        drive(1'b1, 16'h0001, 1'b0, '0, '0);
        wait_free();

        // Random traffic including ignored writes and offers while busy
        repeat (200) drive(1'($urandom % 2), DW'($urandom), 1'(($urandom % 3) == 0),
                           AW'($urandom), DW'($urandom));
        wait_free();
        repeat (3) drive(1'b0, '0, 1'b0, '0, '0);

        chk("tap_queue_empty",   32'(tq.size()), 32'(0));
        chk("done_queue_empty",  32'(dq.size()), 32'(0));
        chk("ready_queue_empty", 32'(rq.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
